// File: rtl/conv1d_obi_pkg.sv
// Shared OBI request/response types and defaults for the conv1d accelerator bus ports.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conv1d_obi_pkg;

    localparam int OBI_AW = 32;
    localparam int OBI_DW = 32;
    localparam int MAX_OUTSTANDING_DEFAULT = 2;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [OBI_DW/8-1:0]   be;
        logic [OBI_AW-1:0]     addr;
        logic [OBI_DW-1:0]     wdata;
    } obi_req_t;

    typedef struct packed {
        logic                  gnt;
        logic                  rvalid;
        logic [OBI_DW-1:0]     rdata;
    } obi_resp_t;

    // Request register state of the SRAM-to-OBI master bridge.
    typedef enum logic {
        REQ_IDLE    = 1'b0,
        REQ_PENDING = 1'b1
    } req_state_e;

endpackage

// File: rtl/conv1d_resp_fifo.sv
// Generic synchronous FIFO with occupancy count.
// Latency: a pushed entry is visible at pop_data the cycle after the push (no bypass).
// Backpressure: push is ignored when full and pop when empty; callers keep both legal.
module conv1d_resp_fifo #(
    parameter int  DEPTH = 2,
    parameter type dtype = logic
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push,
    input  dtype                         push_data,
    input  logic                         pop,
    output dtype                         pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    dtype          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push and pop together keep the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/conv1d_sram_to_obi_mst.sv
// Bridges SRAM-style valid/ready requests from the conv1d datapath onto an OBI master port.
// Latency: OBI req the cycle after handshake; local response one cycle after OBI rvalid.
// Backpressure: credits cap issued-but-unconsumed txns, so a stalled consumer eventually stalls the requester.
module conv1d_sram_to_obi_mst #(
    parameter type obi_req_t       = conv1d_obi_pkg::obi_req_t,
    parameter type obi_resp_t      = conv1d_obi_pkg::obi_resp_t,
    parameter int  MAX_OUTSTANDING = conv1d_obi_pkg::MAX_OUTSTANDING_DEFAULT,
    parameter int  AW              = 32,
    parameter int  DW              = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [DW/8-1:0]   req_be_i,
    input  logic [AW-1:0]     req_addr_i,
    input  logic [DW-1:0]     req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DW-1:0]     rsp_rdata_o,
    output logic              rsp_we_o,
    output obi_req_t          obi_req_o,
    input  obi_resp_t         obi_rsp_i
);
    import conv1d_obi_pkg::*;

    localparam int BEW = DW / 8;
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

    req_state_e      state;
    logic            we_q;
    logic [BEW-1:0]  be_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;

    logic            credit_ok;
    logic            obi_req_vld;
    logic            grant;
    logic            handshake;
    logic            rvalid_acc;
    logic            rsp_pop;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   rsp_count;
    logic            we_flag;
    logic            we_full;
    logic            we_empty;
    logic            rsp_full;
    logic            rsp_empty;
    logic [DW:0]     rsp_entry;

    // Responses already buffered still hold a credit until the consumer takes them,
    // which guarantees an arriving rvalid always finds room in the response FIFO.
    assign credit_ok   = (int'(inflight) + int'(rsp_count)) < MAX_OUTSTANDING;
    assign obi_req_vld = (state == REQ_PENDING) && credit_ok;
    assign grant       = obi_req_vld && obi_rsp_i.gnt;
    assign req_ready_o = (state == REQ_IDLE) || grant;
    assign handshake   = req_valid_i && req_ready_o;
    // An rvalid with nothing in flight (e.g. a stale reply across a reset) is dropped.
    assign rvalid_acc  = obi_rsp_i.rvalid && !we_empty;
    assign rsp_valid_o = !rsp_empty;
    assign rsp_pop     = rsp_valid_o && rsp_ready_i;
    assign rsp_rdata_o = rsp_entry[DW:1];
    assign rsp_we_o    = rsp_entry[0];

    // OBI request fields come straight from the request register so they hold until grant.
    always_comb begin
        obi_req_o       = '0;
        obi_req_o.req   = obi_req_vld;
        obi_req_o.we    = we_q;
        obi_req_o.be    = be_q;
        obi_req_o.addr  = addr_q;
        obi_req_o.wdata = wdata_q;
    end

    // Request register FSM: load on handshake (also on the granting cycle), drop to idle on a bare grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= REQ_IDLE;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (handshake) begin
            state   <= REQ_PENDING;
            we_q    <= req_we_i;
            be_q    <= req_be_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
        end else if (grant) begin
            state   <= REQ_IDLE;
        end
    end

    // Per-txn write flag in grant order; its occupancy is the in-flight count.
    conv1d_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .dtype (logic)
    ) u_we_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (grant),
        .push_data (we_q),
        .pop       (rvalid_acc),
        .pop_data  (we_flag),
        .full      (we_full),
        .empty     (we_empty),
        .count     (inflight)
    );

    // Returned data paired with its write flag, waiting for the consumer.
    conv1d_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .dtype (logic [DW:0])
    ) u_rsp_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (rvalid_acc),
        .push_data ({obi_rsp_i.rdata, we_flag}),
        .pop       (rsp_pop),
        .pop_data  (rsp_entry),
        .full      (rsp_full),
        .empty     (rsp_empty),
        .count     (rsp_count)
    );

`ifndef SYNTHESIS
    logic sva_armed;

    // Protocol checks stay quiet for the first cycle after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sva_armed <= 1'b0;
        else         sva_armed <= 1'b1;
    end

    a_rvalid_needs_inflight: assert property (@(posedge clk_i) disable iff (!rst_ni || !sva_armed)
        obi_rsp_i.rvalid |-> !we_empty);

    a_req_stable_until_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni || !sva_armed)
        (obi_req_o.req && !obi_rsp_i.gnt) |=> (obi_req_o.req && $stable(obi_req_o.addr) &&
        $stable(obi_req_o.we) && $stable(obi_req_o.be) && $stable(obi_req_o.wdata)));

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni || !sva_armed)
        !(grant && we_full) && !(rvalid_acc && rsp_full));
`endif

endmodule

// File: tb/tb_conv1d_sram_to_obi_mst.sv
// Directed bench for the SRAM-to-OBI master bridge with an OBI memory responder and in-order model.
// Latency: responder grants per stall setting and answers after a per-txn latency.
// Backpressure: the consumer ready is toggled to exercise credit exhaustion.
module tb_conv1d_sram_to_obi_mst;
    import conv1d_obi_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [3:0]  req_be_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_we_o;
    obi_req_t    obi_req_o;
    obi_resp_t   obi_rsp_i;

    always #5 clk_i = ~clk_i;

    conv1d_sram_to_obi_mst dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_be_i    (req_be_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_we_o    (rsp_we_o),
        .obi_req_o   (obi_req_o),
        .obi_rsp_i   (obi_rsp_i)
    );

    typedef struct { logic we; logic [31:0] data; } exp_t;
    typedef struct { int due; logic [31:0] data; } bus_rsp_t;

    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    exp_t        log_q[$];
    bus_rsp_t    bus_q[$];
    int          lat_q[$];
    int          stall_left = 0;
    int          grant_cyc[$];
    logic [31:0] grant_addr[$];
    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];

    function automatic logic [31:0] rd_default(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = w[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : rd_default(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // OBI memory responder: decides gnt at the negedge, answers in order after the latency.
    initial begin
        int          lat;
        int          due;
        int          last_due;
        logic [31:0] d;
        last_due = 0;
        obi_rsp_i = '0;
        forever begin
            @(negedge clk_i);
            obi_rsp_i = '0;
            if (!rst_ni) begin
                bus_q.delete();
                last_due = 0;
            end else begin
                if (bus_q.size() > 0 && bus_q[0].due == cyc) begin
                    obi_rsp_i.rvalid = 1'b1;
                    obi_rsp_i.rdata  = bus_q[0].data;
                    void'(bus_q.pop_front());
                end
                if (obi_req_o.req) begin
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        obi_rsp_i.gnt = 1'b1;
                        lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                        due = cyc + lat;
                        if (due <= last_due) due = last_due + 1;
                        last_due = due;
                        if (obi_req_o.we) begin
                            bus_mem[obi_req_o.addr] = merge(bus_mem.exists(obi_req_o.addr) ?
                                bus_mem[obi_req_o.addr] : rd_default(obi_req_o.addr), obi_req_o.wdata, obi_req_o.be);
                            d = 32'h0;
                        end else begin
                            d = bus_mem.exists(obi_req_o.addr) ? bus_mem[obi_req_o.addr] : rd_default(obi_req_o.addr);
                        end
                        bus_q.push_back('{due, d});
                    end
                end
            end
        end
    end

    // Compare process: responses against the in-order model, OBI stability while stalled, grant log.
    initial begin
        exp_t        e;
        logic        stall_seen;
        logic [68:0] saved;
        stall_seen = 1'b0;
        saved = '0;
        forever begin
            @(negedge clk_i);
            #3;
            if (!rst_ni) begin
                stall_seen = 1'b0;
            end else begin
                if (rsp_valid_o && rsp_ready_i) begin
                    if (exp_q.size() == 0) begin
                        fail_now("rsp_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_we", 64'(rsp_we_o), 64'(e.we));
                        if (!e.we) chk("rsp_rdata", 64'(rsp_rdata_o), 64'(e.data));
                        log_q.push_back('{rsp_we_o, rsp_rdata_o});
                    end
                end
                if (stall_seen) begin
                    chk("obi_req_held", 64'(obi_req_o.req), 64'd1);
                    chk("obi_fields_stable", 64'({obi_req_o.we, obi_req_o.be, obi_req_o.addr, obi_req_o.wdata}), 64'(saved));
                end
                stall_seen = obi_req_o.req && !obi_rsp_i.gnt;
                saved = {obi_req_o.we, obi_req_o.be, obi_req_o.addr, obi_req_o.wdata};
                if (obi_req_o.req && obi_rsp_i.gnt) begin
                    grant_cyc.push_back(cyc + 1);
                    grant_addr.push_back(obi_req_o.addr);
                end
            end
        end
    end

    task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        logic hs;
        exp_t e;
        hs = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_be_i    = be;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        for (int i = 0; i < 60; i++) begin
            #4;
            hs = req_ready_o;
            @(posedge clk_i);
            if (hs) break;
            @(negedge clk_i);
        end
        #1;
        req_valid_i = 1'b0;
        if (!hs) begin
            fail_now("req_handshake_timeout");
        end else begin
            e.we = we;
            if (we) begin
                model_mem[addr] = merge(model_read(addr), wdata, be);
                e.data = 32'h0;
            end else begin
                e.data = model_read(addr);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk_i);
            #4;
            done = (exp_q.size() == 0) && !rsp_valid_o && !obi_req_o.req && (bus_q.size() == 0);
        end
        if (!done) fail_now(name);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
        chk({tag, "_obi_req"}, 64'(obi_req_o.req), 64'd0);
        chk({tag, "_obi_addr"}, 64'(obi_req_o.addr), 64'd0);
        chk({tag, "_obi_wdata"}, 64'(obi_req_o.wdata), 64'd0);
        chk({tag, "_obi_we_be"}, 64'({obi_req_o.we, obi_req_o.be}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g0;
        int l0;
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_be_i    = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b1;
        bus_mem[32'h100]   = 32'hDEAD_BEEF;
        model_mem[32'h100] = 32'hDEAD_BEEF;

        repeat (2) @(negedge clk_i);
        #3;
        chk_reset_outputs("reset");
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;

        // Single read with immediate grant and latency 1.
        do_req(1'b0, 4'hF, 32'h100, 32'h0);
        chk("t1_obi_req_after_hs", 64'(obi_req_o.req), 64'd1);
        chk("t1_obi_addr", 64'(obi_req_o.addr), 64'h100);
        chk("t1_obi_we", 64'(obi_req_o.we), 64'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i);
            #1;
            n++;
            if (rsp_valid_o) break;
        end
        chk("t1_rsp_latency", 64'(n), 64'd2);
        chk("t1_rdata_literal", 64'(rsp_rdata_o), 64'hDEAD_BEEF);
        chk("t1_we_literal", 64'(rsp_we_o), 64'd0);
        wait_drain("t1_drain");

        // Write held off by three cycles of gnt low.
        l0 = log_q.size();
        stall_left = 3;
        do_req(1'b1, 4'hF, 32'h200, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            #3;
            chk("t2_obi_req", 64'(obi_req_o.req), 64'd1);
            chk("t2_obi_addr", 64'(obi_req_o.addr), 64'h200);
            chk("t2_obi_wdata", 64'(obi_req_o.wdata), 64'h1234_5678);
            chk("t2_obi_we_be", 64'({obi_req_o.we, obi_req_o.be}), 64'h1F);
            chk("t2_req_ready", 64'(req_ready_o), (i == 3) ? 64'd1 : 64'd0);
        end
        wait_drain("t2_drain");
        chk("t2_rsp_count", 64'(log_q.size() - l0), 64'd1);
        if (log_q.size() > l0) chk("t2_rsp_we", 64'(log_q[l0].we), 64'd1);

        // Four back-to-back reads, consumer always ready.
        l0 = log_q.size();
        g0 = grant_cyc.size();
        do_req(1'b0, 4'hF, 32'h0, 32'h0);
        do_req(1'b0, 4'hF, 32'h4, 32'h0);
        do_req(1'b0, 4'hF, 32'h8, 32'h0);
        do_req(1'b0, 4'hF, 32'hC, 32'h0);
        wait_drain("t3_drain");
        chk("t3_grant_count", 64'(grant_cyc.size() - g0), 64'd4);
        chk("t3_rsp_count", 64'(log_q.size() - l0), 64'd4);
        if (grant_cyc.size() - g0 == 4 && log_q.size() - l0 == 4) begin
            chk("t3_gap01", 64'(grant_cyc[g0+1] - grant_cyc[g0]), 64'd1);
            chk("t3_gap12", 64'(grant_cyc[g0+2] - grant_cyc[g0+1]), 64'd2);
            chk("t3_gap23", 64'(grant_cyc[g0+3] - grant_cyc[g0+2]), 64'd1);
            for (int i = 0; i < 4; i++) begin
                chk("t3_grant_addr", 64'(grant_addr[g0+i]), 64'(4 * i));
            end
            chk("t3_rdata0", 64'(log_q[l0].data), 64'hA5A5_0000);
            chk("t3_rdata1", 64'(log_q[l0+1].data), 64'hA5A5_0004);
            chk("t3_rdata2", 64'(log_q[l0+2].data), 64'hA5A5_0008);
            chk("t3_rdata3", 64'(log_q[l0+3].data), 64'hA5A5_000C);
        end

        // Credit exhaustion with the consumer stalled.
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        g0 = grant_cyc.size();
        do_req(1'b0, 4'hF, 32'h20, 32'h0);
        do_req(1'b0, 4'hF, 32'h24, 32'h0);
        do_req(1'b0, 4'hF, 32'h28, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            #3;
            chk("t4_req_low_no_credit", 64'(obi_req_o.req), 64'd0);
        end
        chk("t4_two_granted", 64'(grant_cyc.size() - g0), 64'd2);
        chk("t4_rsp_valid", 64'(rsp_valid_o), 64'd1);
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            #4;
            if (grant_cyc.size() - g0 >= 3) break;
        end
        chk("t4_third_granted", 64'(grant_cyc.size() - g0), 64'd3);
        if (grant_cyc.size() - g0 >= 3) chk("t4_third_addr", 64'(grant_addr[g0+2]), 64'h28);
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        wait_drain("t4_drain");

        // Mixed writes and reads with varying rvalid latency.
        l0 = log_q.size();
        lat_q = '{3, 1, 2};
        do_req(1'b1, 4'hF, 32'h10, 32'hCAFE_0010);
        do_req(1'b0, 4'hF, 32'h14, 32'h0);
        do_req(1'b1, 4'b0011, 32'h18, 32'h0000_AB18);
        do_req(1'b0, 4'hF, 32'h18, 32'h0);
        wait_drain("t5_drain");
        chk("t5_rsp_count", 64'(log_q.size() - l0), 64'd4);
        if (log_q.size() - l0 == 4) begin
            chk("t5_we_seq", 64'({log_q[l0].we, log_q[l0+1].we, log_q[l0+2].we, log_q[l0+3].we}), 64'b1010);
            chk("t5_rdata_14", 64'(log_q[l0+1].data), 64'hA5A5_0014);
            chk("t5_rdata_18_partial", 64'(log_q[l0+3].data), 64'hA5A5_AB18);
        end

        // Reset with two reads in flight or buffered and a third pending.
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        lat_q = '{3, 3, 3};
        do_req(1'b0, 4'hF, 32'h30, 32'h0);
        do_req(1'b0, 4'hF, 32'h34, 32'h0);
        do_req(1'b0, 4'hF, 32'h38, 32'h0);
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        chk("t6_pre_rsp_valid", 64'(rsp_valid_o), 64'd1);
        chk("t6_pre_req_ready", 64'(req_ready_o), 64'd0);
        rst_ni = 1'b0;
        #1;
        chk_reset_outputs("t6_midreset");
        exp_q.delete();
        lat_q.delete();
        stall_left = 0;
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        l0 = log_q.size();
        do_req(1'b0, 4'hF, 32'h100, 32'h0);
        wait_drain("t6_drain");
        chk("t6_rsp_count", 64'(log_q.size() - l0), 64'd1);
        if (log_q.size() > l0) chk("t6_rdata", 64'(log_q[l0].data), 64'hDEAD_BEEF);

        chk("end_model_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
